// File: rtl/board_generator.sv
// board_generator
//   Wishbone writing master that builds a fresh Minesweeper board in the
//   16x16 board memory. A build has three passes:
//     1. clear all 256 cells,
//     2. place mines at pseudo-random in-bounds cells,
//     3. write every in-bounds cell's neighbouring-mine count.
//
// Ports
//   clk, rst            system clock, asynchronous active-high reset
//   start               one-cycle build request (ignored while busy)
//   rows_m1, cols_m1    board rows/columns minus one, captured at start
//   mine_count          requested mines, captured at start
//   seed                LFSR seed (zero selects LFSR_DEFAULT), captured at start
//   busy                high while a build is in progress
//   done                one-cycle pulse when the board is complete
//   wb_*                single-transfer Wishbone master (CYC == STB); each
//                       transfer is followed by one mandatory idle cycle
//
// Cell byte: bit7 mine, bit6 flag, bit5 defused, bits4:1 mine count, bit0 spare.
module board_generator #(
  parameter logic [15:0] LFSR_DEFAULT = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [3:0]  rows_m1,
  input  logic [3:0]  cols_m1,
  input  logic [7:0]  mine_count,
  input  logic [15:0] seed,
  output logic        busy,
  output logic        done,
  output logic [7:0]  wb_adr_o,
  output logic [7:0]  wb_dat_o,
  input  logic [7:0]  wb_dat_i,
  output logic        wb_we_o,
  output logic        wb_stb_o,
  output logic        wb_cyc_o,
  input  logic        wb_ack_i
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLEAR = 3'd1,
    S_PLACE = 3'd2,
    S_COUNT = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  // Per-cell sub-steps of the counting pass
  typedef enum logic [1:0] {
    C_SELF  = 2'd0,
    C_NB    = 2'd1,
    C_WRITE = 2'd2
  } csub_t;

  // Fibonacci LFSR, taps 16,14,13,11, shifting left, feedback into bit 0
  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
  endfunction

  state_t      state_r;
  csub_t       csub_r;
  logic        strobe_r;
  logic [3:0]  rows_r;
  logic [3:0]  cols_r;
  logic [7:0]  mines_r;
  logic [7:0]  placed_r;
  logic [15:0] lfsr_r;
  logic [8:0]  clr_idx_r;
  logic        pl_write_r;
  logic [3:0]  cr_r;
  logic [3:0]  cc_r;
  logic [3:0]  nb_r;
  logic [3:0]  sum_r;
  logic        self_mine_r;
  logic        cells_done_r;

  logic [8:0]  area_s;
  logic [8:0]  max_mines_s;
  logic [7:0]  clamp_s;
  logic [15:0] lfsr_next_s;
  logic        cand_ok_s;
  logic [4:0]  dr_s;
  logic [4:0]  dc_s;
  logic [4:0]  nr_s;
  logic [4:0]  nc_s;
  logic        nb_ok_s;
  logic        unused_dat_s;

  // CYC and STB come from one register so they can never differ
  assign wb_cyc_o = strobe_r;
  assign wb_stb_o = strobe_r;

  // Only the mine bit of a read cell matters to this block
  assign unused_dat_s = ^wb_dat_i[6:0];

  // Mine clamp: at least one cell must stay safe
  always_comb begin
    area_s      = ({5'd0, rows_m1} + 9'd1) * ({5'd0, cols_m1} + 9'd1);
    max_mines_s = area_s - 9'd1;
    if ({1'b0, mine_count} < max_mines_s) begin
      clamp_s = mine_count;
    end else begin
      clamp_s = max_mines_s[7:0];
    end
  end

  // Next placement candidate from the stepped LFSR
  always_comb begin
    lfsr_next_s = lfsr_step(lfsr_r);
    cand_ok_s   = (lfsr_next_s[7:4] <= rows_r) && (lfsr_next_s[3:0] <= cols_r);
  end

  // Neighbour address; 5-bit arithmetic so -1 and 16 both land in bit 4 (out of bounds)
  always_comb begin
    dr_s = 5'd0;
    dc_s = 5'd0;
    case (nb_r[2:0])
      3'd0:    begin dr_s = 5'h1F; dc_s = 5'h1F; end  // NW
      3'd1:    begin dr_s = 5'h1F; dc_s = 5'h00; end  // N
      3'd2:    begin dr_s = 5'h1F; dc_s = 5'h01; end  // NE
      3'd3:    begin dr_s = 5'h00; dc_s = 5'h1F; end  // W
      3'd4:    begin dr_s = 5'h00; dc_s = 5'h01; end  // E
      3'd5:    begin dr_s = 5'h01; dc_s = 5'h1F; end  // SW
      3'd6:    begin dr_s = 5'h01; dc_s = 5'h00; end  // S
      3'd7:    begin dr_s = 5'h01; dc_s = 5'h01; end  // SE
      default: begin dr_s = 5'h00; dc_s = 5'h00; end
    endcase
    nr_s    = {1'b0, cr_r} + dr_s;
    nc_s    = {1'b0, cc_r} + dc_s;
    nb_ok_s = !nr_s[4] && !nc_s[4] && (nr_s[3:0] <= rows_r) && (nc_s[3:0] <= cols_r);
  end

  // Build sequencer and Wishbone master. A transfer in flight only waits
  // for ACK; all decisions are taken in cycles with no strobe, which makes
  // the cycle after each ACK the required idle cycle and ignores stale ACKs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r      <= S_IDLE;
      csub_r       <= C_SELF;
      strobe_r     <= 1'b0;
      wb_we_o      <= 1'b0;
      wb_adr_o     <= 8'h00;
      wb_dat_o     <= 8'h00;
      busy         <= 1'b0;
      done         <= 1'b0;
      rows_r       <= 4'd0;
      cols_r       <= 4'd0;
      mines_r      <= 8'd0;
      placed_r     <= 8'd0;
      lfsr_r       <= LFSR_DEFAULT;
      clr_idx_r    <= 9'd0;
      pl_write_r   <= 1'b0;
      cr_r         <= 4'd0;
      cc_r         <= 4'd0;
      nb_r         <= 4'd0;
      sum_r        <= 4'd0;
      self_mine_r  <= 1'b0;
      cells_done_r <= 1'b0;
    end else begin
      done <= 1'b0;
      if (strobe_r) begin
        if (wb_ack_i) begin
          strobe_r <= 1'b0;
          case (state_r)
            S_CLEAR: clr_idx_r <= clr_idx_r + 9'd1;
            S_PLACE: begin
              if (wb_we_o) begin
                placed_r   <= placed_r + 8'd1;
                pl_write_r <= 1'b0;
              end else if (!wb_dat_i[7]) begin
                pl_write_r <= 1'b1;
              end else begin
                pl_write_r <= 1'b0;
              end
            end
            S_COUNT: begin
              case (csub_r)
                C_SELF: begin
                  self_mine_r <= wb_dat_i[7];
                  sum_r       <= 4'd0;
                  nb_r        <= 4'd0;
                  csub_r      <= C_NB;
                end
                C_NB: begin
                  sum_r <= sum_r + {3'd0, wb_dat_i[7]};
                  nb_r  <= nb_r + 4'd1;
                end
                C_WRITE: begin
                  csub_r <= C_SELF;
                  if (cc_r == cols_r) begin
                    cc_r <= 4'd0;
                    if (cr_r == rows_r) begin
                      cells_done_r <= 1'b1;
                    end else begin
                      cr_r <= cr_r + 4'd1;
                    end
                  end else begin
                    cc_r <= cc_r + 4'd1;
                  end
                end
                default: csub_r <= C_SELF;
              endcase
            end
            default: strobe_r <= 1'b0;
          endcase
        end
      end else begin
        case (state_r)
          S_IDLE: begin
            if (start) begin
              rows_r       <= rows_m1;
              cols_r       <= cols_m1;
              mines_r      <= clamp_s;
              lfsr_r       <= (seed == 16'h0000) ? LFSR_DEFAULT : seed;
              placed_r     <= 8'd0;
              pl_write_r   <= 1'b0;
              clr_idx_r    <= 9'd0;
              cr_r         <= 4'd0;
              cc_r         <= 4'd0;
              cells_done_r <= 1'b0;
              csub_r       <= C_SELF;
              busy         <= 1'b1;
              state_r      <= S_CLEAR;
            end
          end
          S_CLEAR: begin
            if (clr_idx_r[8]) begin
              state_r <= S_PLACE;
            end else begin
              strobe_r <= 1'b1;
              wb_we_o  <= 1'b1;
              wb_adr_o <= clr_idx_r[7:0];
              wb_dat_o <= 8'h00;
            end
          end
          S_PLACE: begin
            if (pl_write_r) begin
              // Address still holds the candidate that was just read
              strobe_r <= 1'b1;
              wb_we_o  <= 1'b1;
              wb_dat_o <= 8'h80;
            end else if (placed_r == mines_r) begin
              state_r <= S_COUNT;
            end else begin
              lfsr_r <= lfsr_next_s;
              if (cand_ok_s) begin
                strobe_r <= 1'b1;
                wb_we_o  <= 1'b0;
                wb_adr_o <= lfsr_next_s[7:0];
                wb_dat_o <= 8'h00;
              end
            end
          end
          S_COUNT: begin
            case (csub_r)
              C_SELF: begin
                if (cells_done_r) begin
                  done    <= 1'b1;
                  busy    <= 1'b0;
                  state_r <= S_DONE;
                end else begin
                  strobe_r <= 1'b1;
                  wb_we_o  <= 1'b0;
                  wb_adr_o <= {cr_r, cc_r};
                  wb_dat_o <= 8'h00;
                end
              end
              C_NB: begin
                if (nb_r[3]) begin
                  strobe_r <= 1'b1;
                  wb_we_o  <= 1'b1;
                  wb_adr_o <= {cr_r, cc_r};
                  wb_dat_o <= {self_mine_r, 2'b00, sum_r, 1'b0};
                  csub_r   <= C_WRITE;
                end else if (nb_ok_s) begin
                  strobe_r <= 1'b1;
                  wb_we_o  <= 1'b0;
                  wb_adr_o <= {nr_s[3:0], nc_s[3:0]};
                  wb_dat_o <= 8'h00;
                end else begin
                  nb_r <= nb_r + 4'd1;
                end
              end
              default: csub_r <= C_SELF;
            endcase
          end
          S_DONE:  state_r <= S_IDLE;
          default: state_r <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_board_generator.sv
module tb_board_generator;

  logic        clk;
  logic        rst;
  logic        start;
  logic [3:0]  rows_m1;
  logic [3:0]  cols_m1;
  logic [7:0]  mine_count;
  logic [15:0] seed;
  logic        busy;
  logic        done;
  logic [7:0]  wb_adr_o;
  logic [7:0]  wb_dat_o;
  logic [7:0]  wb_dat_i = 8'h00;
  logic        wb_we_o;
  logic        wb_stb_o;
  logic        wb_cyc_o;
  logic        wb_ack_i = 1'b0;

  board_generator dut (
    .clk(clk), .rst(rst), .start(start), .rows_m1(rows_m1), .cols_m1(cols_m1),
    .mine_count(mine_count), .seed(seed), .busy(busy), .done(done),
    .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_dat_i(wb_dat_i),
    .wb_we_o(wb_we_o), .wb_stb_o(wb_stb_o), .wb_cyc_o(wb_cyc_o), .wb_ack_i(wb_ack_i)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_vec  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_vec++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // ---------------- board memory slave ----------------
  logic [7:0] mem [256];
  int         cfg_wait  = 0;
  bit         cfg_stale = 1'b0;
  logic [3:0] cfg_rm    = 4'd0;
  logic [3:0] cfg_cm    = 4'd0;
  int         scrub_req = 0;
  int         scrub_ack = 0;
  int         wr_cnt    = 0;
  int         rd_cnt    = 0;
  int         oob_cnt   = 0;
  int         wait_left = 0;
  logic       stale_ph  = 1'b0;

  // Slave: registered ACK after 0..cfg_wait wait states, optional stale ACK in the idle cycle
  always @(posedge clk) begin
    if (scrub_req != scrub_ack) begin
      for (int i = 0; i < 256; i++) mem[i] <= 8'($urandom);
      wr_cnt    <= 0;
      rd_cnt    <= 0;
      oob_cnt   <= 0;
      scrub_ack <= scrub_req;
    end
    if (wb_ack_i) begin
      if (cfg_stale && !stale_ph) begin
        wb_ack_i <= 1'b1;
        stale_ph <= 1'b1;
      end else begin
        wb_ack_i <= 1'b0;
        stale_ph <= 1'b0;
      end
    end else if (wb_stb_o) begin
      if (wait_left == 0) begin
        wb_ack_i  <= 1'b1;
        wait_left <= int'($urandom_range(32'(cfg_wait), 0));
        if (wb_we_o) begin
          mem[wb_adr_o] <= wb_dat_o;
          wr_cnt <= wr_cnt + 1;
          if (wr_cnt >= 256 && (wb_adr_o[7:4] > cfg_rm || wb_adr_o[3:0] > cfg_cm))
            oob_cnt <= oob_cnt + 1;
        end else begin
          wb_dat_i <= mem[wb_adr_o];
          rd_cnt   <= rd_cnt + 1;
        end
      end else begin
        wait_left <= wait_left - 1;
      end
    end
  end

  // ---------------- bus protocol checker ----------------
  logic       p_stb = 1'b0;
  logic       p_ack = 1'b0;
  logic       p_we  = 1'b0;
  logic       p_done = 1'b0;
  logic [7:0] p_adr = 8'h00;
  logic [7:0] p_dat = 8'h00;
  int         viol  = 0;

  // Protocol rules sampled mid-cycle
  always @(negedge clk) begin
    if (rst) begin
      p_stb  <= 1'b0;
      p_ack  <= 1'b0;
      p_done <= 1'b0;
    end else begin
      viol <= viol + int'(wb_cyc_o != wb_stb_o)
                   + int'(p_stb && p_ack && wb_stb_o)
                   + int'(p_stb && !p_ack && (!wb_stb_o || wb_adr_o != p_adr ||
                                              wb_we_o != p_we || wb_dat_o != p_dat))
                   + int'(p_done && done);
      p_stb  <= wb_stb_o;
      p_ack  <= wb_ack_i;
      p_we   <= wb_we_o;
      p_adr  <= wb_adr_o;
      p_dat  <= wb_dat_o;
      p_done <= done;
    end
  end

  // ---------------- scoreboard ----------------
  typedef struct {
    string         nm;
    logic [3:0]    rm;
    logic [3:0]    cm;
    logic [2047:0] board;
    int            mines;
    int            reads;
    int            writes;
    int            safe06;
  } exp_t;

  exp_t       exp_q[$];
  int         done_seen = 0;
  logic [255:0] last_layout = '0;

  // Reference board built straight from the algorithm description
  function automatic logic [2047:0] model_board(input logic [3:0] rm, input logic [3:0] cm,
                                                input logic [7:0] mc, input logic [15:0] sd);
    logic [7:0]    m [256];
    logic [2047:0] res;
    logic [15:0]   l;
    int lim, placed, rows, cols, s, nr, nc;
    rows = int'(rm) + 1;
    cols = int'(cm) + 1;
    lim  = rows * cols - 1;
    if (int'(mc) < lim) lim = int'(mc);
    for (int i = 0; i < 256; i++) m[i] = 8'h00;
    l = (sd == 16'h0000) ? 16'hACE1 : sd;
    placed = 0;
    for (int g = 0; g < 200000 && placed < lim; g++) begin
      l = {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
      if (int'(l[7:4]) < rows && int'(l[3:0]) < cols && !m[l[7:0]][7]) begin
        m[l[7:0]] = 8'h80;
        placed++;
      end
    end
    res = '0;
    for (int r = 0; r < rows; r++) begin
      for (int c = 0; c < cols; c++) begin
        s = 0;
        for (int dr = -1; dr <= 1; dr++) begin
          for (int dc = -1; dc <= 1; dc++) begin
            nr = r + dr;
            nc = c + dc;
            if (!(dr == 0 && dc == 0) && nr >= 0 && nr < rows && nc >= 0 && nc < cols)
              if (m[nr * 16 + nc][7]) s++;
          end
        end
        res[(r * 16 + c) * 8 +: 8] = {m[r * 16 + c][7], 2'b00, 4'(s), 1'b0};
      end
    end
    return res;
  endfunction

  task automatic check_board();
    exp_t       e;
    int         diff;
    int         mines_got;
    int         safe_got;
    logic [7:0] av;
    done_seen++;
    if (exp_q.size() == 0) begin
      chk("unexpected_done", 1, 0);
    end else begin
      e = exp_q.pop_front();
      diff = -1;
      mines_got = 0;
      safe_got = 0;
      for (int a = 0; a < 256; a++) begin
        av = 8'(a);
        last_layout[a] = mem[a][7];
        if (diff < 0 && mem[a] != e.board[a * 8 +: 8]) diff = a;
        if (av[7:4] <= e.rm && av[3:0] <= e.cm) begin
          if (mem[a][7]) mines_got++;
          if (mem[a] == 8'h06) safe_got++;
        end
      end
      n_vec++;
      if (diff >= 0) begin
        n_fail++;
        $display("FAIL %s_board: cell %02h got %02h expected %02h", e.nm, diff, mem[diff],
                 e.board[diff * 8 +: 8]);
      end
      chk({e.nm, "_mines"}, mines_got, e.mines);
      chk({e.nm, "_oob_writes"}, oob_cnt, 0);
      if (e.reads >= 0) chk({e.nm, "_reads"}, rd_cnt, e.reads);
      if (e.writes >= 0) chk({e.nm, "_writes"}, wr_cnt, e.writes);
      if (e.safe06 >= 0) chk({e.nm, "_safe06"}, safe_got, e.safe06);
    end
  endtask

  // Monitor: a done pulse presents a finished board
  always @(negedge clk) begin
    if (!rst && done) check_board();
  end

  // ---------------- stimulus ----------------
  task automatic chk_reset(input string nm);
    chk(nm, {busy, done, wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o}, 0);
  endtask

  task automatic prep(input logic [3:0] rm, input logic [3:0] cm, input int mw, input bit st);
    cfg_wait  = mw;
    cfg_stale = st;
    cfg_rm    = rm;
    cfg_cm    = cm;
    scrub_req++;
    for (int k = 0; k < 10 && scrub_ack != scrub_req; k++) @(negedge clk);
  endtask

  task automatic run(input string nm, input logic [3:0] rm, input logic [3:0] cm,
                     input logic [7:0] mc, input logic [15:0] sd, input int mw, input bit st,
                     input int mines, input int reads, input int writes, input int safe06,
                     input int glitch);
    exp_t e;
    int   d0;
    prep(rm, cm, mw, st);
    e.nm = nm; e.rm = rm; e.cm = cm; e.board = model_board(rm, cm, mc, sd);
    e.mines = mines; e.reads = reads; e.writes = writes; e.safe06 = safe06;
    exp_q.push_back(e);
    d0 = done_seen;
    @(negedge clk);
    rows_m1 = rm; cols_m1 = cm; mine_count = mc; seed = sd; start = 1'b1;
    chk({nm, "_busy_before"}, busy, 0);
    @(negedge clk);
    start = 1'b0;
    chk({nm, "_busy_rise"}, busy, 1);
    for (int k = 0; k < 60000 && done_seen == d0; k++) begin
      @(negedge clk);
      if (glitch > 0 && k == glitch) begin
        rows_m1 = 4'd0; cols_m1 = 4'd0; mine_count = 8'd1; seed = 16'h0001; start = 1'b1;
      end else begin
        start = 1'b0;
      end
    end
    start = 1'b0;
    if (done_seen == d0) begin
      chk({nm, "_timeout"}, 0, 1);
      exp_q.delete();
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
    end else begin
      repeat (4) @(negedge clk);
      chk({nm, "_done_pulses"}, done_seen - d0, 1);
      chk({nm, "_busy_after"}, busy, 0);
    end
  endtask

  logic [255:0] layout_a;

  initial begin
    rst = 1'b1; start = 1'b0; rows_m1 = 4'd0; cols_m1 = 4'd0; mine_count = 8'd0; seed = 16'h0000;
    repeat (3) @(negedge clk);
    chk_reset("reset_values");
    rst = 1'b0;
    @(negedge clk);

    // 4x4, no mines: 256+16 writes, 16 self reads + 84 neighbour reads
    run("b4x4_m0", 4'd3, 4'd3, 8'd0, 16'h5A5A, 0, 1'b0, 0, 100, 272, -1, 0);
    // 16x16, 40 mines, random waits, stale ACKs, start pulsed mid-build
    run("b16_m40", 4'd15, 4'd15, 8'd40, 16'h1234, 3, 1'b1, 40, -1, -1, -1, 150);
    // 2x2 clamped to 3 mines, one safe cell reading 8'h06
    run("b2x2_m200", 4'd1, 4'd1, 8'd200, 16'h0BAD, 1, 1'b0, 3, -1, -1, 1, 0);
    // zero seed behaves as 16'hACE1
    run("b16_seed0", 4'd15, 4'd15, 8'd40, 16'h0000, 0, 1'b0, 40, -1, -1, -1, 0);
    layout_a = last_layout;
    run("b16_ace1", 4'd15, 4'd15, 8'd40, 16'hACE1, 0, 1'b0, 40, -1, -1, -1, 0);
    chk("seed0_layout", layout_a == last_layout, 1);

    // Reset in the middle of placement, with a start pulsed while busy
    prep(4'd7, 4'd7, 1, 1'b0);
    @(negedge clk);
    rows_m1 = 4'd7; cols_m1 = 4'd7; mine_count = 8'd10; seed = 16'h7777; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 5000 && rd_cnt == 0; k++) @(negedge clk);
    chk("rst_reached_place", rd_cnt > 0, 1);
    rows_m1 = 4'd3; cols_m1 = 4'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk_reset("rst_mid_place");
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk_reset("rst_after_release");
    run("b8x8_m10", 4'd7, 4'd7, 8'd10, 16'hBEEF, 3, 1'b1, 10, -1, -1, -1, 0);

    chk("pending_expect", exp_q.size(), 0);
    chk("protocol", viol, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
